load_extend_unit: RTL
=====================

Name: load_extend_unit

Overview:
- Sequential load-data formatter for the vesp datapath, sitting between the data-memory read port and the register-file writeback.
- Accepts a load request (byte offset, size, signedness) and fetches one or two memory words. Two words are needed when the access crosses a word boundary.
- Extracts the addressed field, then zero- or sign-extends it to XLEN.
- This generalises the fixed-width combinational extender to any XLEN, runtime-selected size, unaligned access and a valid/ready handshake.

Parameters:
- XLEN, 32, datapath and memory word width in bits; legal values 32 or 64.
- ALLOW_MISALIGNED, 1: 1 = misaligned loads are serviced, possibly in two beats; 0 = misaligned loads return err without any memory access.
- OFFW, $clog2(XLEN/8), byte-offset width (derived).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request
- req_offset  in  OFFW  byte offset of the load within its aligned word
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when XLEN = 64)
- req_uext  in  1  1 = zero-extend, 0 = sign-extend
- mem_req  out  1  memory beat request
- mem_word_sel  out  1  0 = aligned word holding the offset, 1 = next word (address + XLEN/8)
- mem_ack  in  1  memory beat complete; mem_rdata valid in the same cycle
- mem_rdata  in  XLEN  memory read data
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  XLEN  extended result
- res_misaligned  out  1  access was not naturally aligned
- res_err  out  1  illegal size, or misaligned access with ALLOW_MISALIGNED = 0

Behaviour:
- Definitions:
  - bytes = 1 << req_size.
  - misaligned = (offset mod bytes) != 0.
  - crossing = offset + bytes > XLEN/8.
- Reset (asynchronous, any state): state = IDLE; outputs as follows.
  - mem_req = 0, mem_word_sel = 0.
  - res_valid = 0, res_data = 0, res_misaligned = 0, res_err = 0.
  - Internal buffers = 0.
  - An in-flight access is discarded and no result is produced.
- FSM states: IDLE, BEAT0, BEAT1, DONE. All outputs are registered or decoded from state (Moore); no combinational path from inputs to outputs.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch offset, size, uext and misaligned.
  - If size is illegal, or misaligned and ALLOW_MISALIGNED = 0: go to DONE with res_err = 1 and res_data = 0. No memory request is issued.
  - Otherwise go to BEAT0.
- BEAT0:
  - mem_req = 1, mem_word_sel = 0; held until mem_ack.
  - On mem_ack: store mem_rdata in lo_buf.
  - If crossing, go to BEAT1. Otherwise compute the result and go to DONE.
- BEAT1:
  - mem_req = 1, mem_word_sel = 1; held until mem_ack.
  - On mem_ack: compute the result using mem_rdata as hi_buf, then go to DONE.
- DONE:
  - res_valid = 1 with res_data, res_misaligned and res_err stable until res_ready.
  - On res_valid & res_ready: go to IDLE and deassert res_valid in the next cycle.
  - req_ready = 0; no request overlap.
- Result computation:
  - Form {hi, lo} (2*XLEN bits, hi = 0 for a single beat).
  - Shift right by offset*8 and keep the low bytes*8 bits as the field.
  - If uext = 1: upper bits = 0.
  - If uext = 0: upper bits = field MSB.
  - Size equal to XLEN passes the field through unchanged.
- Latency (mem_ack in the first cycle of each beat):
  - Request accepted in cycle 0 → mem_req in cycle 1 → res_valid in cycle 2 (single beat) or cycle 3 (two beats).
  - Error path: res_valid in cycle 1.
- Waiting on memory: mem_ack may be delayed arbitrarily; the FSM waits. mem_ack outside BEAT0/BEAT1 is ignored.
- Throughput: one load in flight, at most one request per 2 cycles.

Test Plan (XLEN = 32):
- Byte sign/zero extension: byte, offset 3, rdata 0x8F123456.
  - uext = 0 → res_data 0xFFFFFF8F.
  - uext = 1 → 0x0000008F.
  - Both: one mem_req beat, res_misaligned = 0.
- Halfword sign extension: half, offset 2, rdata 0x80011234, uext = 0 → 0xFFFF8001.
- Crossing word, ALLOW_MISALIGNED = 1: word, offset 1, beat0 rdata 0xDDCCBBAA, beat1 0x44332211.
  - mem_word_sel goes 0 then 1.
  - res_data 0x11DDCCBB, res_misaligned = 1, res_err = 0.
- Misaligned rejected, ALLOW_MISALIGNED = 0: same request as above → mem_req never asserted; res_err = 1, res_data = 0 in cycle 1.
- Illegal size: size 3 at XLEN = 32 → res_err = 1, no memory beat.
- Backpressure and delayed ack:
  - Delay mem_ack by 2 cycles → mem_req is held.
  - Hold res_ready = 0 for 3 cycles → res_valid and res_data stay stable and req_ready = 0.
  - Then accept the result → IDLE the next cycle.
- Reset mid-access: assert reset_n = 0 during BEAT1.
  - mem_req and res_valid drop immediately.
  - After release, a byte load at offset 0 with rdata 0x0000007F returns 0x0000007F normally.

Source files
------------

// File: rtl/load_extend_unit.sv
// Sequential load formatter: fetches one or two memory words for a load,
// extracts the addressed field and zero/sign-extends it to XLEN.
module load_extend_unit #(
    parameter int XLEN             = 32,
    parameter int ALLOW_MISALIGNED = 1,
    parameter int OFFW             = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OFFW-1:0] req_offset,
    input  logic [1:0]      req_size,
    input  logic            req_uext,
    output logic            mem_req,
    output logic            mem_word_sel,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic            res_misaligned,
    output logic            res_err
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t          state, state_next;
    logic [OFFW-1:0] off_q;
    logic [1:0]      size_q;
    logic            uext_q;
    logic [XLEN-1:0] lo_buf;

    logic [OFFW:0]   req_bytes, cur_bytes;
    logic            req_mis, req_illegal, req_reject, crossing;
    logic [XLEN-1:0] beat_result;

    // Shift the {hi,lo} window down to the field, then mask and extend.
    function automatic logic [XLEN-1:0] extend_field(
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic [OFFW-1:0] off,
        input logic [1:0]      size,
        input logic            uext
    );
        logic [XLEN-1:0] field, mask;
        logic            sign;
        field = XLEN'({hi, lo} >> {off, 3'b000});
        case (size)
            2'd0:    begin mask = XLEN'(8'hFF);         sign = field[7];      end
            2'd1:    begin mask = XLEN'(16'hFFFF);      sign = field[15];     end
            2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); sign = field[31];     end
            default: begin mask = '1;                   sign = field[XLEN-1]; end
        endcase
        return (field & mask) | ((!uext && sign) ? ~mask : '0);
    endfunction

    always_comb begin
        req_bytes   = (OFFW + 1)'(1) << req_size;
        req_mis     = (({1'b0, req_offset} & (req_bytes - (OFFW + 1)'(1))) != '0);
        req_illegal = (XLEN == 32) && (req_size == 2'd3);
        req_reject  = req_illegal || (req_mis && (ALLOW_MISALIGNED == 0));
        cur_bytes   = (OFFW + 1)'(1) << size_q;
        crossing    = (({1'b0, off_q} + cur_bytes) > (OFFW + 1)'(XLEN / 8));
        // In BEAT1 the first word is the low half; a single beat has hi = 0.
        if (state == BEAT1)
            beat_result = extend_field(mem_rdata, lo_buf, off_q, size_q, uext_q);
        else
            beat_result = extend_field('0, mem_rdata, off_q, size_q, uext_q);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (req_valid) state_next = req_reject ? DONE : BEAT0;
            BEAT0: if (mem_ack)   state_next = crossing ? BEAT1 : DONE;
            BEAT1: if (mem_ack)   state_next = DONE;
            DONE:  if (res_ready) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            off_q          <= '0;
            size_q         <= '0;
            uext_q         <= 1'b0;
            lo_buf         <= '0;
            res_data       <= '0;
            res_misaligned <= 1'b0;
            res_err        <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (req_valid) begin
                    off_q          <= req_offset;
                    size_q         <= req_size;
                    uext_q         <= req_uext;
                    res_misaligned <= req_mis;
                    res_err        <= req_reject;
                    if (req_reject) res_data <= '0;
                end
                BEAT0: if (mem_ack) begin
                    lo_buf <= mem_rdata;
                    if (!crossing) res_data <= beat_result;
                end
                BEAT1: if (mem_ack) res_data <= beat_result;
                default: ;
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign mem_req      = (state == BEAT0) || (state == BEAT1);
    assign mem_word_sel = (state == BEAT1);
    assign res_valid    = (state == DONE);

endmodule
